// File: rtl/ldpc_ber_tester_din_channel.sv
// Binary-symmetric-channel emulator on the LDPC DIN stream: per-lane LFSRs decide
// which LLRs get sign-flipped, with a running count of injected flips.
module ldpc_ber_tester_din_channel #(
  parameter int          LANES     = 16,
  parameter int          LLR_WIDTH = 8,
  parameter logic [15:0] SEED_ID   = 16'h0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [15:0]                  threshold,
  input  logic                         clear_count,
  input  logic [LANES*LLR_WIDTH-1:0]   s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [LANES*LLR_WIDTH-1:0]   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [63:0]                  flip_count
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [LLR_WIDTH-1:0] LLR_MIN = {1'b1, {(LLR_WIDTH-1){1'b0}}};
  localparam logic [LLR_WIDTH-1:0] LLR_MAX = {1'b0, {(LLR_WIDTH-1){1'b1}}};
  localparam logic [LLR_WIDTH-1:0] LLR_ONE = {{(LLR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [15:0] lane_seed(input int lane);
    logic [31:0] raw_v;
    logic [15:0] seed_v;
    raw_v  = 32'h0000_ACE1 + 32'(lane) * 32'h0000_1F35;
    seed_v = raw_v[15:0] ^ SEED_ID;
    if (seed_v == 16'h0000) lane_seed = 16'h0001;
    else                    lane_seed = seed_v;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // The most negative code has no positive twin, so it clamps to the largest positive value.
  function automatic logic [LLR_WIDTH-1:0] flip_llr(input logic [LLR_WIDTH-1:0] llr);
    if (llr == LLR_MIN) flip_llr = LLR_MAX;
    else                flip_llr = ~llr + LLR_ONE;
  endfunction

  logic [15:0]                lfsr_r [LANES];
  logic [LANES-1:0]           flip_mask_s;
  logic [LANES*LLR_WIDTH-1:0] proc_data_s;
  logic [CW-1:0]              flip_pop_s;
  logic                       hs_s;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign hs_s          = s_axis_tvalid && s_axis_tready;

  // Per-lane flip decision from the pre-advance LFSR state, flipped data and flip popcount.
  always_comb begin
    flip_mask_s = '0;
    proc_data_s = s_axis_tdata;
    flip_pop_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      flip_mask_s[i] = en && (lfsr_r[i] < threshold);
      if (flip_mask_s[i]) begin
        proc_data_s[i*LLR_WIDTH +: LLR_WIDTH] = flip_llr(s_axis_tdata[i*LLR_WIDTH +: LLR_WIDTH]);
        flip_pop_s = flip_pop_s + CNT_ONE;
      end else begin
        proc_data_s[i*LLR_WIDTH +: LLR_WIDTH] = s_axis_tdata[i*LLR_WIDTH +: LLR_WIDTH];
      end
    end
  end

  // Lane LFSRs step once per accepted input beat, independent of en and tlast.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) lfsr_r[i] <= lane_seed(i);
    end else if (hs_s) begin
      for (int i = 0; i < LANES; i++) lfsr_r[i] <= lfsr_next(lfsr_r[i]);
    end
  end

  // Single output register stage with skid-free ready propagation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (hs_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= proc_data_s;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Flip counter; a clear wins over the same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flip_count <= 64'd0;
    end else if (clear_count) begin
      flip_count <= 64'd0;
    end else if (hs_s) begin
      flip_count <= flip_count + {{(64-CW){1'b0}}, flip_pop_s};
    end
  end

endmodule

// File: tb/tb_ldpc_ber_tester_din_channel.sv
// Randomized scoreboard bench for ldpc_ber_tester_din_channel against a behavioural channel model.
module tb_ldpc_ber_tester_din_channel;

  logic         clk;
  logic         reset;
  logic         en;
  logic [15:0]  threshold;
  logic         clear_count;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [63:0]  flip_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t       sb [$];
  logic [15:0] ref_lfsr [16];
  logic [63:0] ref_count;
  bit          ref_mvalid;

  ldpc_ber_tester_din_channel dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .threshold     (threshold),
    .clear_count   (clear_count),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .flip_count    (flip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_seed(input int i);
    int v;
    v = (32'hACE1 + i * 32'h1F35) % 32'h10000;
    if (v == 0) v = 1;
    return v[15:0];
  endfunction

  function automatic int seed_flips(input logic [15:0] thr);
    int n = 0;
    for (int i = 0; i < 16; i++) if (ref_seed(i) < thr) n++;
    return n;
  endfunction

  task automatic ref_init();
    for (int i = 0; i < 16; i++) ref_lfsr[i] = ref_seed(i);
    ref_count  = 64'd0;
    ref_mvalid = 1'b0;
    sb.delete();
  endtask

  function automatic logic [127:0] gen_beat(input int mode);
    logic [127:0] d;
    logic [7:0]   special [6] = '{8'h80, 8'h00, 8'h7F, 8'h81, 8'h01, 8'hFF};
    case (mode)
      1: d = 128'h0102030405060708090A0B0C0D0E0F10;
      2: d = {16{8'h10}};
      3: for (int i = 0; i < 16; i++)
           d[8*i +: 8] = ($urandom_range(7) < 6) ? special[$urandom_range(5)] : 8'($urandom);
      default: d = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return d;
  endfunction

  // Reference model: predicts each accepted beat, the counter and the handshake signals.
  initial begin : model
    logic         exp_ready;
    logic [127:0] od;
    int           pop;
    int           v;
    ref_init();
    forever begin
      @(negedge clk);
      if (reset) begin
        ref_init();
      end else begin
        chk("m_valid", m_axis_tvalid, ref_mvalid);
        exp_ready = !ref_mvalid || m_axis_tready;
        chk("s_ready", s_axis_tready, exp_ready);
        chk("flip_count", flip_count, ref_count);
        if (s_axis_tvalid && exp_ready) begin
          od  = s_axis_tdata;
          pop = 0;
          for (int i = 0; i < 16; i++) begin
            if (en && (ref_lfsr[i] < threshold)) begin
              v = -int'($signed(s_axis_tdata[8*i +: 8]));
              if (v > 127) v = 127;
              od[8*i +: 8] = v[7:0];
              pop++;
            end
            ref_lfsr[i] = (ref_lfsr[i] >> 1) ^ (ref_lfsr[i][0] ? 16'hB400 : 16'h0000);
          end
          sb.push_back('{data: od, last: s_axis_tlast});
          ref_count  = clear_count ? 64'd0 : ref_count + 64'(pop);
          ref_mvalid = 1'b1;
        end else begin
          if (clear_count)   ref_count  = 64'd0;
          if (m_axis_tready) ref_mvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  initial begin : monitor
    beat_t        exp_b;
    bit           stalled;
    logic [127:0] held_d;
    logic         held_l;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", m_axis_tvalid, 1'b1);
          chk("stall_data", m_axis_tdata, held_d);
          chk("stall_last", m_axis_tlast, held_l);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow: output beat %h with empty scoreboard", m_axis_tdata);
          end else begin
            exp_b = sb.pop_front();
            if (m_axis_tdata !== exp_b.data || m_axis_tlast !== exp_b.last) begin
              failures++;
              $display("FAIL out_beat: got %h/%b expected %h/%b",
                       m_axis_tdata, m_axis_tlast, exp_b.data, exp_b.last);
            end
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held_d  = m_axis_tdata;
        held_l  = m_axis_tlast;
      end
    end
  end

  task automatic run_beats(input int n, input bit en_v, input logic [15:0] thr,
                           input int mode, input int rdy_pct, input int vld_pct);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    en        = en_v;
    threshold = thr;
    while (sent < n && cyc < n * 40 + 100) begin
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      if (!s_axis_tvalid && ($urandom_range(99) < vld_pct)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = gen_beat(mode);
        s_axis_tlast  = ($urandom_range(3) == 0);
      end
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        s_axis_tvalid = 1'b0;
      end
      cyc++;
    end
    checks++;
    if (sent < n) begin
      failures++;
      $display("FAIL run_beats_timeout: sent %0d required %0d", sent, n);
    end
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // First beat after reset: decisions come straight from the lane seeds.
  task automatic seed_beat_check(input string tag);
    logic [127:0] exp_d;
    for (int i = 0; i < 16; i++) exp_d[8*i +: 8] = (ref_seed(i) < 16'hACE2) ? 8'hF0 : 8'h10;
    en            = 1'b1;
    threshold     = 16'hACE2;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {16{8'h10}};
    s_axis_tlast  = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, m_axis_tvalid, 1'b1);
    chk({tag, "_lane0"}, m_axis_tdata[7:0], 8'hF0);
    chk({tag, "_data"}, m_axis_tdata, exp_d);
    chk({tag, "_count"}, flip_count, 64'(seed_flips(16'hACE2)));
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    reset         = 1'b1;
    en            = 1'b0;
    threshold     = 16'h0000;
    clear_count   = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", m_axis_tvalid, 1'b0);
    chk("rst_data", m_axis_tdata, 128'd0);
    chk("rst_last", m_axis_tlast, 1'b0);
    chk("rst_count", flip_count, 64'd0);
    reset = 1'b0;

    run_beats(4, 1'b0, 16'hFFFF, 1, 100, 100);
    drain();
    chk("pass_count", flip_count, 64'd0);

    do_reset();
    seed_beat_check("seed");

    run_beats(60, 1'b1, 16'hFFFF, 3, 100, 100);
    drain();

    run_beats(1000, 1'b1, 16'h4000, 0, 50, 80);
    drain();

    // Clear and handshake in the same cycle.
    en            = 1'b1;
    threshold     = 16'hFFFF;
    clear_count   = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = gen_beat(0);
    @(posedge clk); #1;
    clear_count   = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("clear_collision", flip_count, 64'd0);
    @(posedge clk); #1;
    drain();

    clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    run_beats(10000, 1'b1, 16'h0666, 0, 100, 100);
    drain();
    checks++;
    if (flip_count < 64'd3800 || flip_count > 64'd4200) begin
      failures++;
      $display("FAIL stats_range: flip_count %0d required 3800..4200", flip_count);
    end

    // Async reset while an output beat is held.
    en            = 1'b1;
    threshold     = 16'h8000;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = gen_beat(0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    chk("pre_rst_valid", m_axis_tvalid, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_drop_valid", m_axis_tvalid, 1'b0);
    chk("rst_drop_data", m_axis_tdata, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seed_beat_check("post_reset");

    run_beats(40, 1'b1, 16'h2000, 3, 70, 90);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_ber_tester_din_channel.md
Name: ldpc_ber_tester_din_channel

Overview:
Channel emulator placed on the DIN path between the tester's DIN output buffer and the LDPC decoder's DIN slave. Each 128-bit beat carries 16 signed 8-bit LLRs. The block negates (sign-flips) each LLR independently with a programmable probability, which models a binary symmetric channel. It also counts every injected flip so software can compute the raw channel BER next to the decoded BER.

Parameters:
LANES, 16, number of LLR lanes per beat (data width = LANES*LLR_WIDTH)
LLR_WIDTH, 8, bits per LLR, two's complement
SEED_ID, 0, 16-bit value XORed into every lane LFSR seed; gives distinct streams per tester instance

Ports:
clk  in  1  datapath clock
reset  in  1  asynchronous, active-high reset
en  in  1  1: injection active; 0: pass-through (LFSRs still advance)
threshold  in  16  flip probability = threshold/65536 per lane per beat
clear_count  in  1  single-cycle pulse that zeroes flip_count
s_axis_tdata  in  128  input LLR beat; lane i = bits [8i+7:8i]
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of codeword
m_axis_tdata  out  128  output LLR beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  registered copy of s_axis_tlast
flip_count  out  64  total LLRs flipped since reset/clear

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, flip_count=0. Each lane LFSR is loaded with its seed.
- Seed for lane i: ((0xACE1 + i*0x1F35) mod 2^16) XOR SEED_ID. If the result is 0x0000, 0x0001 is used instead. With SEED_ID=0, lane 0 = 0xACE1.
- LFSR: 16-bit Galois, right-shift. next = (s>>1) XOR (s[0] ? 0xB400 : 0). Every lane advances exactly once per input handshake (s_axis_tvalid && s_axis_tready) and never at any other time.
- Flip decision for lane i on a handshake: flip_i = en && (lfsr_i < threshold). The comparison uses the LFSR value before the advance. threshold=0 means no flips ever.
- Flip operation: out = -in in two's complement. -128 (0x80) saturates to +127 (0x7F). An input of 0 stays 0 but still counts as a flip.
- Pipeline: one register stage, latency 1 cycle.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational).
  - On a handshake, the output register loads the processed data and tlast, and m_axis_tvalid becomes 1.
  - If m_axis_tready=1 and there is no input handshake, m_axis_tvalid becomes 0.
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
  - Full throughput: 1 beat/cycle when m_axis_tready is held high.
- flip_count: on each input handshake, add popcount(flip mask), 0..16. The counter wraps at 2^64.
- clear_count has priority over a same-cycle add: flip_count becomes 0 and that beat's flips are discarded from the count. The beat's data is still flipped.
- en and threshold are sampled at the handshake cycle. Changing them mid-codeword is legal and takes effect on the next beat.
- tlast has no effect on the LFSRs or the counter; the random stream continues across codeword boundaries.
- Reset asserted mid-transfer: the output beat is dropped immediately and the LFSRs reseed. The upstream source must be reset at the same time.

Test Plan:
- Pass-through: en=0, threshold=0xFFFF, send 4 beats of 0x0102...10, m_ready=1. Output equals input, 1-cycle latency, tlast preserved, flip_count=0.
- Single lane flip: SEED_ID=0, en=1, threshold=0xACE2, first beat all lanes 0x10. Lane 0 output = 0xF0. flip_count equals the number of lanes whose seed is < 0xACE2, checked against the reference model.
- Saturation/zero: threshold=0xFFFF (all lanes flip unless LFSR=0xFFFF). Lanes carrying 0x80 -> 0x7F, 0x00 -> 0x00, 0x7F -> 0x81. Count increments per flipped lane.
- Backpressure: random m_axis_tready at about 50% over 1000 beats. No beat is lost or duplicated, data is stable while stalled, and the LFSR sequence matches the model indexed by handshake count.
- Statistics: threshold=0x0666 (about 2.5%), 10000 beats. flip_count is within ±5% of 4000 and exactly matches the model.
- Clear collision: pulse clear_count on the same cycle as a handshake. flip_count=0 on the next cycle. Async reset mid-stream drops m_axis_tvalid to 0 immediately, and the first post-reset beat reproduces the seed decisions.
